// File: rtl/capture_sequencer_if.sv
// Capture-path bundle between the D5M pixel path and the SDRAM write FIFOs.
// master = capture_sequencer side, slave = camera/FIFO side.
interface capture_sequencer_if #(
  parameter int BURST_W = 8,
  parameter int FCNT_W  = 32
) ();
  logic               iSTART;
  logic               iSTOP;
  logic [1:0]         iMODE;
  logic [BURST_W-1:0] iBURST_LEN;
  logic               iFVAL;
  logic               iDVAL;
  logic               oWR_EN;
  logic               oWR_LOAD;
  logic               oBUSY;
  logic               oCAPTURING;
  logic               oFRAME_DONE;
  logic [FCNT_W-1:0]  oFRAME_CNT;
  logic               oPIX_ERR;
  logic [1:0]         dbg_state;

  // iDVAL/oWR_EN form a valid-only stream: there is no ready. Every cycle
  // with oWR_EN=1 carries one pixel that the write FIFO must accept.
  modport master (
    input  iSTART, iSTOP, iMODE, iBURST_LEN, iFVAL, iDVAL,
    output oWR_EN, oWR_LOAD, oBUSY, oCAPTURING, oFRAME_DONE, oFRAME_CNT,
           oPIX_ERR, dbg_state
  );

  modport slave (
    output iSTART, iSTOP, iMODE, iBURST_LEN, iFVAL, iDVAL,
    input  oWR_EN, oWR_LOAD, oBUSY, oCAPTURING, oFRAME_DONE, oFRAME_CNT,
           oPIX_ERR, dbg_state
  );
endinterface

// File: rtl/capture_sequencer.sv
// Frame capture sequencer: gates pixel-valid to whole frames, pulses the
// write-address reload per frame. Optional pixel-count check: CAPSEQ_PIXCHK_EN.
module capture_sequencer #(
  parameter int BURST_W       = 8,
  parameter int FCNT_W        = 32,
  parameter int PIX_PER_FRAME = 307200,
  parameter int PIX_CNT_W     = 20
) (
  input  logic iCLK,
  input  logic iRST,
  capture_sequencer_if.master bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam logic [1:0] MODE_CONT  = 2'b00;
  localparam logic [1:0] MODE_BURST = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [BURST_W-1:0] burst_rem_q, burst_rem_d;
  logic               stop_pend_q, stop_pend_d;
  logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic               wr_load_q, wr_load_d;
  logic               frame_done_q, frame_done_d;
  logic               start_prev_q, start_prev_d;
  logic               stop_prev_q, stop_prev_d;
  logic               fval_prev_q, fval_prev_d;

  logic               start_re, stop_re, fval_re, fval_fe;
  logic               wr_en;
  logic               last_frame;
  logic [BURST_W-1:0] burst_len_eff;

  always_comb begin
    start_re      = bus.iSTART & ~start_prev_q;
    stop_re       = bus.iSTOP  & ~stop_prev_q;
    fval_re       = bus.iFVAL  & ~fval_prev_q;
    fval_fe       = ~bus.iFVAL & fval_prev_q;
    burst_len_eff = (bus.iBURST_LEN == '0) ? BURST_W'(1) : bus.iBURST_LEN;
    wr_en         = bus.iDVAL & (state_q == ST_CAPTURE);

    // Snapshot covers both 01 and 11; continuous never ends on its own.
    last_frame    = stop_pend_q | stop_re |
                    ((mode_q != MODE_CONT) && (mode_q != MODE_BURST)) |
                    ((mode_q == MODE_BURST) && (burst_rem_q == BURST_W'(1)));

    state_d      = state_q;
    mode_d       = mode_q;
    burst_rem_d  = burst_rem_q;
    stop_pend_d  = stop_pend_q;
    frame_cnt_d  = frame_cnt_q;
    wr_load_d    = 1'b0;
    frame_done_d = 1'b0;
    start_prev_d = bus.iSTART;
    stop_prev_d  = bus.iSTOP;
    fval_prev_d  = bus.iFVAL;

    case (state_q)
      ST_IDLE: begin
        if (start_re && !stop_re) begin
          mode_d      = bus.iMODE;
          burst_rem_d = burst_len_eff;
          stop_pend_d = 1'b0;
          state_d     = ST_ARM;
        end
      end
      ST_ARM: begin
        // fval_re only fires on a rising edge, so a frame already under way
        // when we arrive here is skipped.
        if (stop_re) begin
          state_d = ST_IDLE;
        end else if (fval_re) begin
          wr_load_d = 1'b1;
          state_d   = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (stop_re) stop_pend_d = 1'b1;
        if (fval_fe) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
          burst_rem_d  = burst_rem_q - BURST_W'(1);
          state_d      = last_frame ? ST_IDLE : ST_ARM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= ST_IDLE;
      mode_q       <= 2'b00;
      burst_rem_q  <= '0;
      stop_pend_q  <= 1'b0;
      frame_cnt_q  <= '0;
      wr_load_q    <= 1'b0;
      frame_done_q <= 1'b0;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      fval_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      burst_rem_q  <= burst_rem_d;
      stop_pend_q  <= stop_pend_d;
      frame_cnt_q  <= frame_cnt_d;
      wr_load_q    <= wr_load_d;
      frame_done_q <= frame_done_d;
      start_prev_q <= start_prev_d;
      stop_prev_q  <= stop_prev_d;
      fval_prev_q  <= fval_prev_d;
    end
  end

`ifdef CAPSEQ_PIXCHK_EN
  logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d, pix_cnt_inc;
  logic                 pix_err_q, pix_err_d;

  always_comb begin
    pix_cnt_inc = (wr_en && (pix_cnt_q != '1)) ? pix_cnt_q + PIX_CNT_W'(1) : pix_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    pix_err_d   = pix_err_q;
    if ((state_q == ST_IDLE) && start_re && !stop_re) pix_err_d = 1'b0;
    if ((state_q == ST_ARM) && fval_re && !stop_re)   pix_cnt_d = '0;
    if (state_q == ST_CAPTURE) begin
      pix_cnt_d = pix_cnt_inc;
      // The falling-edge cycle's own strobe is included in the total.
      if (fval_fe && (pix_cnt_inc != PIX_CNT_W'(PIX_PER_FRAME))) pix_err_d = 1'b1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pix_cnt_q <= '0;
      pix_err_q <= 1'b0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      pix_err_q <= pix_err_d;
    end
  end

  assign bus.oPIX_ERR = pix_err_q;
`else
  assign bus.oPIX_ERR = 1'b0;
`endif

  assign bus.oWR_EN      = wr_en;
  assign bus.oWR_LOAD    = wr_load_q;
  assign bus.oFRAME_DONE = frame_done_q;
  assign bus.oFRAME_CNT  = frame_cnt_q;
  assign bus.oBUSY       = (state_q != ST_IDLE);
  assign bus.oCAPTURING  = (state_q == ST_CAPTURE);
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: directed scenarios plus randomized frames, all
// checked every cycle against a frame-level model of the sequencing rules.
module tb_capture_sequencer;

  localparam int PPF = 16;
`ifdef CAPSEQ_PIXCHK_EN
  localparam logic PIXCHK = 1'b1;
`else
  localparam logic PIXCHK = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start, stop, fval, dval;
  logic [1:0] mode;
  logic [7:0] blen;

  capture_sequencer_if #(.BURST_W(8), .FCNT_W(32)) bus_w ();
  capture_sequencer_if #(.BURST_W(8), .FCNT_W(2))  bus_n ();

  assign bus_w.iSTART = start;  assign bus_n.iSTART = start;
  assign bus_w.iSTOP  = stop;   assign bus_n.iSTOP  = stop;
  assign bus_w.iMODE  = mode;   assign bus_n.iMODE  = mode;
  assign bus_w.iBURST_LEN = blen; assign bus_n.iBURST_LEN = blen;
  assign bus_w.iFVAL  = fval;   assign bus_n.iFVAL  = fval;
  assign bus_w.iDVAL  = dval;   assign bus_n.iDVAL  = dval;

  capture_sequencer #(.BURST_W(8), .FCNT_W(32), .PIX_PER_FRAME(PPF), .PIX_CNT_W(8))
    dut (.iCLK(clk), .iRST(rst), .bus(bus_w.master));
  capture_sequencer #(.BURST_W(8), .FCNT_W(2), .PIX_PER_FRAME(PPF), .PIX_CNT_W(8))
    dut_n (.iCLK(clk), .iRST(rst), .bus(bus_n.master));

  int checks = 0;
  int errors = 0;
  int n_load = 0;
  int n_done = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: a run is a number of frames (-1 = unlimited)
  logic        m_active, m_in_frame, m_stop_req, m_load, m_done, m_pix_err;
  int          m_left, m_pix;
  int unsigned m_cnt;
  logic        m_start_d, m_stop_d, m_fval_d;

  task automatic model_reset();
    m_active = 0; m_in_frame = 0; m_stop_req = 0; m_load = 0; m_done = 0;
    m_pix_err = 0; m_left = 0; m_pix = 0; m_cnt = 0;
    m_start_d = 0; m_stop_d = 0; m_fval_d = 0;
  endtask

  task automatic model_step();
    logic su, sp, fu, fd;
    su = start & ~m_start_d;
    sp = stop & ~m_stop_d;
    fu = fval & ~m_fval_d;
    fd = ~fval & m_fval_d;
    m_load = 0;
    m_done = 0;
    if (!m_active) begin
      if (su && !sp) begin
        m_active = 1; m_in_frame = 0; m_stop_req = 0; m_pix_err = 0;
        if (mode == 2'b00)      m_left = -1;
        else if (mode == 2'b10) m_left = (blen == 0) ? 1 : int'(blen);
        else                    m_left = 1;
      end
    end else if (!m_in_frame) begin
      if (sp) m_active = 0;
      else if (fu) begin
        m_load = 1; m_in_frame = 1; m_pix = 0;
      end
    end else begin
      if (dval) m_pix++;
      if (sp) m_stop_req = 1;
      if (fd) begin
        m_done = 1;
        m_cnt++;
        if (m_pix != PPF) m_pix_err = 1;
        if (m_left > 0) m_left--;
        m_in_frame = 0;
        if (m_stop_req || m_left == 0) m_active = 0;
      end
    end
    m_start_d = start; m_stop_d = stop; m_fval_d = fval;
  endtask

  // scoreboard: every cycle, outputs vs model, then advance model for the next edge
  always @(negedge clk) begin
    logic [31:0] c32;
    #2;
    if (rst) model_reset();
    c32 = m_cnt;
    check("wr_en",      {31'b0, bus_w.oWR_EN},      {31'b0, dval & m_in_frame});
    check("wr_load",    {31'b0, bus_w.oWR_LOAD},    {31'b0, m_load});
    check("frame_done", {31'b0, bus_w.oFRAME_DONE}, {31'b0, m_done});
    check("busy",       {31'b0, bus_w.oBUSY},       {31'b0, m_active});
    check("capturing",  {31'b0, bus_w.oCAPTURING},  {31'b0, m_in_frame});
    check("frame_cnt",  bus_w.oFRAME_CNT,           c32);
    check("cnt_narrow", {30'b0, bus_n.oFRAME_CNT},  {30'b0, c32[1:0]});
    check("wr_en_n",    {31'b0, bus_n.oWR_EN},      {31'b0, dval & m_in_frame});
    check("pix_err",    {31'b0, bus_w.oPIX_ERR},    {31'b0, m_pix_err & PIXCHK});
    n_load += int'(bus_w.oWR_LOAD);
    n_done += int'(bus_w.oFRAME_DONE);
    if (!rst) model_step();
  end

  // driver tasks: inputs change only on the falling edge
  task automatic settle();
    @(negedge clk); #3;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) stop = 1;
    @(negedge clk) stop = 0;
  endtask

  task automatic frame(input int npix, input int gap);
    int n;
    n = npix;
    @(negedge clk) begin fval = 1; dval = 0; end
    while (n > 0) begin
      @(negedge clk) dval = 1'($urandom_range(0, 1));
      if (dval) n--;
    end
    @(negedge clk) begin dval = 0; fval = 0; end
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int base_load, base_done;
    start = 0; stop = 0; mode = 0; blen = 0; fval = 0; dval = 0; rst = 1;
    idle(3);
    dval = 1;
    settle();
    check("rst_cnt",   bus_w.oFRAME_CNT, 32'd0);
    check("rst_busy",  {31'b0, bus_w.oBUSY}, 32'd0);
    check("rst_wr_en", {31'b0, bus_w.oWR_EN}, 32'd0);
    @(negedge clk) begin dval = 0; rst = 0; end
    idle(2);

    // snapshot, start during a frame: that frame is skipped
    mode = 2'b01;
    fork
      frame(PPF, 3);
      begin idle(3); pulse_start(); end
    join
    frame(PPF, 3);
    idle(2);
    settle();
    check("snap_cnt",  bus_w.oFRAME_CNT, 32'd1);
    check("snap_load", n_load, 1);
    check("snap_done", n_done, 1);
    check("snap_busy", {31'b0, bus_w.oBUSY}, 32'd0);

    // burst of 3 offered 4 frames
    base_load = n_load; base_done = n_done;
    mode = 2'b10; blen = 8'd3;
    pulse_start(); idle(2);
    repeat (4) frame(PPF, 3);
    settle();
    check("burst_cnt",  bus_w.oFRAME_CNT, 32'd4);
    check("burst_load", n_load - base_load, 3);
    check("burst_done", n_done - base_done, 3);
    check("burst_busy", {31'b0, bus_w.oBUSY}, 32'd0);

    // burst length 0 behaves as 1
    blen = 8'd0;
    pulse_start(); idle(2);
    repeat (2) frame(PPF, 3);
    settle();
    check("burst0_cnt", bus_w.oFRAME_CNT, 32'd5);

    // continuous, stop mid-frame: that frame still completes
    mode = 2'b00;
    pulse_start(); idle(2);
    frame(PPF, 2);
    fork
      frame(PPF, 2);
      begin idle(6); pulse_stop(); end
    join
    frame(PPF, 2);
    settle();
    check("stop_cnt",  bus_w.oFRAME_CNT, 32'd7);
    check("stop_busy", {31'b0, bus_w.oBUSY}, 32'd0);

    // stop while armed
    base_load = n_load;
    pulse_start(); idle(2);
    pulse_stop(); idle(1);
    settle();
    check("arm_stop_busy", {31'b0, bus_w.oBUSY}, 32'd0);
    frame(PPF, 2);
    check("arm_stop_load", n_load - base_load, 0);

    // simultaneous start and stop: stop wins
    @(negedge clk) begin start = 1; stop = 1; end
    @(negedge clk) begin start = 0; stop = 0; end
    settle();
    check("both_busy", {31'b0, bus_w.oBUSY}, 32'd0);

    // narrow counter wraps 3 -> 0
    check("narrow_pre", {30'b0, bus_n.oFRAME_CNT}, 32'd3);
    mode = 2'b11;
    pulse_start(); idle(2);
    frame(PPF, 3);
    settle();
    check("narrow_wrap", {30'b0, bus_n.oFRAME_CNT}, 32'd0);
    check("wide_8",      bus_w.oFRAME_CNT, 32'd8);

    // pixel-count check
    mode = 2'b00;
    pulse_start(); idle(2);
    frame(PPF - 1, 3);
    settle();
    check("pix_short", {31'b0, bus_w.oPIX_ERR}, {31'b0, PIXCHK});
    frame(PPF, 2);
    settle();
    check("pix_sticky", {31'b0, bus_w.oPIX_ERR}, {31'b0, PIXCHK});
    pulse_stop(); idle(2);
    pulse_start(); idle(1);
    settle();
    check("pix_clear", {31'b0, bus_w.oPIX_ERR}, 32'd0);
    pulse_stop(); idle(2);

    // randomized runs
    repeat (25) begin
      mode = 2'($urandom_range(0, 3));
      blen = 8'($urandom_range(0, 3));
      fork
        begin repeat (3) frame($urandom_range(PPF - 2, PPF + 1), $urandom_range(1, 4)); end
        begin idle($urandom_range(0, 30)); pulse_start(); end
        begin if ($urandom_range(0, 1) == 1) begin idle($urandom_range(0, 80)); pulse_stop(); end end
      join
    end
    pulse_stop();
    frame(PPF, 2);
    idle(2);

    // async reset mid-capture
    mode = 2'b00;
    pulse_start(); idle(2);
    @(negedge clk) fval = 1;
    @(negedge clk) dval = 1;
    settle();
    check("pre_rst_wr_en", {31'b0, bus_w.oWR_EN}, 32'd1);
    @(posedge clk); #2;
    rst = 1;
    #1;
    check("rst_mid_wr_en", {31'b0, bus_w.oWR_EN}, 32'd0);
    check("rst_mid_cnt",   bus_w.oFRAME_CNT, 32'd0);
    idle(2);
    settle();
    check("rst_hold_busy", {31'b0, bus_w.oBUSY}, 32'd0);
    @(negedge clk) begin rst = 0; dval = 0; end
    @(negedge clk) fval = 0;
    frame(PPF, 2);
    settle();
    check("no_resume_cnt",  bus_w.oFRAME_CNT, 32'd0);
    check("no_resume_busy", {31'b0, bus_w.oBUSY}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
